// File: rtl/reg_we_n.sv
// Single WIDTH-bit storage register with async active-low reset,
// synchronous clear and write enable.
module reg_we_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over write, so a write issued with clr is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file_2r1w.sv
// DEPTH x WIDTH register file: one synchronous write port, two combinational
// read ports, whole-array clear, optional hardwired zero register and bypass.
module register_file_2r1w #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              WE,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wa_is_zero;
  logic             byp_ok;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_store
      logic we_i;
      assign we_i = WE && (wa == ADDR_W'(i));
      reg_we_n #(
        .WIDTH (WIDTH)
      ) u_reg (
        .clk   (clk),
        .rst_n (reset),
        .clr   (clr),
        .we    (we_i),
        .d     (wd),
        .q     (regs[i])
      );
    end
  end

  assign wa_is_zero = (ZERO_REG != 0) && (wa == '0);

  // Forward only writes that will actually land; reset keeps reads at zero.
  assign byp_ok = (BYPASS != 0) && reset && WE && !clr && !wa_is_zero;

  always_comb begin
    rd1 = regs[ra1];
    if (byp_ok && (ra1 == wa)) begin
      rd1 = wd;
    end
    if ((ZERO_REG != 0) && (ra1 == '0)) begin
      rd1 = '0;
    end
  end

  always_comb begin
    rd2 = regs[ra2];
    if (byp_ok && (ra2 == wa)) begin
      rd2 = wd;
    end
    if ((ZERO_REG != 0) && (ra2 == '0)) begin
      rd2 = '0;
    end
  end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench: two configurations (zero-reg+bypass, and neither) driven in parallel,
// checked against an array model plus a few literal expectations.
module tb_register_file_2r1w;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic       we = 1'b0;
  logic [2:0] wa = '0;
  logic [7:0] wd = '0;
  logic [2:0] ra1 = '0;
  logic [2:0] ra2 = '0;
  logic [7:0] a_rd1, a_rd2, b_rd1, b_rd2;

  int total = 0;
  int bad = 0;

  logic [7:0] mem_a [8];
  logic [7:0] mem_b [8];

  always #5 clk = ~clk;

  register_file_2r1w #(
    .WIDTH(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .clk(clk), .reset(reset), .clr(clr), .WE(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(a_rd1), .rd2(a_rd2)
  );

  register_file_2r1w #(
    .WIDTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)
  ) dut_b (
    .clk(clk), .reset(reset), .clr(clr), .WE(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2)
  );

  // Model of storage contents for each configuration.
  always @(posedge clk or negedge reset) begin
    if (!reset || clr) begin
      for (int i = 0; i < 8; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else if (we) begin
      if (wa != 3'd0) mem_a[wa] <= wd;
      mem_b[wa] <= wd;
    end
  end

  function automatic logic [7:0] model_rd(input bit zero, input bit byp, input logic [2:0] ra);
    logic [7:0] stored;
    stored = zero ? mem_a[ra] : mem_b[ra];
    if (zero && ra == 3'd0) return 8'h00;
    if (byp && reset && we && !clr && ra == wa && !(zero && wa == 3'd0)) return wd;
    return stored;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_a_rd1", a_rd1, model_rd(1'b1, 1'b1, ra1));
    check("model_a_rd2", a_rd2, model_rd(1'b1, 1'b1, ra2));
    check("model_b_rd1", b_rd1, model_rd(1'b0, 1'b0, ra1));
    check("model_b_rd2", b_rd2, model_rd(1'b0, 1'b0, ra2));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    we = 1'b1; wa = a; wd = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    // Reset then read
    #33;
    reset = 1'b1;
    ra1 = 3'd5; ra2 = 3'd7;
    #1;
    check("rst_a_rd1", a_rd1, 8'h00);
    check("rst_a_rd2", a_rd2, 8'h00);
    check("rst_b_rd1", b_rd1, 8'h00);
    check("rst_b_rd2", b_rd2, 8'h00);

    // Basic write/read
    step();
    wr(3'd3, 8'hA5);
    ra1 = 3'd3; ra2 = 3'd2;
    #1;
    check("wr_a_rd1", a_rd1, 8'hA5);
    check("wr_a_rd2", a_rd2, 8'h00);
    check("wr_b_rd1", b_rd1, 8'hA5);
    check("wr_b_rd2", b_rd2, 8'h00);

    // Zero register
    wr(3'd0, 8'hFF);
    ra1 = 3'd0;
    #1;
    check("zero_a_rd1", a_rd1, 8'h00);
    check("zero_b_rd1", b_rd1, 8'hFF);

    // Bypass
    wr(3'd4, 8'h11);
    we = 1'b1; wa = 3'd4; wd = 8'h3C; ra1 = 3'd4;
    #1;
    check("byp_a_pre", a_rd1, 8'h3C);
    check("byp_b_pre", b_rd1, 8'h11);
    step();
    we = 1'b0;
    #1;
    check("byp_b_post", b_rd1, 8'h3C);

    // Clear priority over write, and no bypass of the clear
    wr(3'd1, 8'h22);
    wr(3'd6, 8'h77);
    clr = 1'b1; we = 1'b1; wa = 3'd6; wd = 8'h99; ra1 = 3'd6;
    #1;
    check("clr_a_pre", a_rd1, 8'h77);
    check("clr_b_pre", b_rd1, 8'h77);
    step();
    clr = 1'b0; we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i);
      #1;
      check("clr_a_all", a_rd1, 8'h00);
      check("clr_b_all", b_rd1, 8'h00);
    end

    // Async reset between edges; pending write under reset is dropped
    wr(3'd2, 8'h5A);
    ra1 = 3'd2;
    #1;
    check("ar_a_before", a_rd1, 8'h5A);
    @(negedge clk);
    #2;
    we = 1'b1; wa = 3'd2; wd = 8'hAA;
    reset = 1'b0;
    #1;
    check("ar_a_async", a_rd1, 8'h00);
    check("ar_b_async", b_rd1, 8'h00);
    step();
    reset = 1'b1;
    we = 1'b0;
    #1;
    check("ar_a_nowrite", a_rd1, 8'h00);
    check("ar_b_nowrite", b_rd1, 8'h00);

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 600; n++) begin
      we  = ($urandom_range(3) != 0);
      clr = ($urandom_range(15) == 0);
      wa  = 3'($urandom_range(7));
      wd  = 8'($urandom_range(255));
      ra1 = ($urandom_range(3) == 0) ? wa : 3'($urandom_range(7));
      ra2 = ($urandom_range(3) == 0) ? ra1 : 3'($urandom_range(7));
      if ($urandom_range(63) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        check("rnd_rst_a", a_rd1, 8'h00);
        check("rnd_rst_b", b_rd2, 8'h00);
        #1;
        reset = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
- Parametrised register file for the datapath: DEPTH words of WIDTH bits each.
- One synchronous write port, two combinational read ports, and a synchronous clear of the whole array.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Built from an array of write-enabled registers; feeds the ALU operand muxes and takes results back through the write port.

Parameters:
- WIDTH, 8, data width of each register in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, when 1 register 0 always reads 0 and writes to it are discarded.
- BYPASS, 1, when 1 a read of the address being written this cycle returns the write data combinationally.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- clr  input  1  synchronous clear of all registers on the next rising edge.
- WE  input  1  write enable.
- wa  input  ADDR_W  write address.
- wd  input  WIDTH  write data.
- ra1  input  ADDR_W  read address, port 1.
- ra2  input  ADDR_W  read address, port 2.
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.

Behaviour:
- Reset:
  - reset=0 clears every register to 0 immediately, independent of clk.
  - rd1 and rd2 therefore read 0 while in reset.
  - Release of reset takes effect with no clock needed; the first write can occur on the first rising edge after reset=1.
- Write:
  - On posedge clk with reset=1, clr=0, WE=1: reg[wa] <= wd.
  - Exception: wa=0 with ZERO_REG=1 makes no change.
  - WE=0: all registers hold.
  - Write latency: 1 cycle; data is visible through storage from the edge onward.
- Clear:
  - On posedge clk with clr=1, all registers <= 0.
  - clr has priority over WE in the same cycle; the write is lost.
  - Async reset has priority over both.
- Read:
  - rdN = reg[raN], purely combinational, no clock latency.
  - ZERO_REG=1 and raN=0 gives rdN=0 regardless of storage or bypass.
- Bypass (BYPASS=1):
  - If WE=1, clr=0, raN==wa, and the target is not the zero register, rdN = wd in the same cycle, before the edge.
  - If clr=1, rdN shows current storage; there is no bypass of the clear.
  - BYPASS=0: rdN shows the old value until after the edge.
- Both read ports may address the same register, or the write address, simultaneously, with identical results.
- Addresses always decode in range; no out-of-range case exists since DEPTH = 2**ADDR_W.
- Reset asserted mid-cycle while WE=1: the register array goes to 0 at once, and the pending write does not occur on that edge if reset is still 0 at the edge.
- Width rule: no arithmetic; all data paths are exactly WIDTH bits, with no sign or zero extension.

Decomposition:
- No shared package needed; all sizing comes from parameters.
- One natural sub-module: reg_we_n, a WIDTH-parametrised register with clk, active-low async reset, sync clear, WE, d, and q. It is instantiated DEPTH times, or DEPTH-1 times when ZERO_REG=1.
- Parent holds the write decoder, the two read muxes and the bypass compare.

Test Plan:
- Reset then read: hold reset=0 for 30 ns, release, set ra1=5 and ra2=7 -> rd1=8'h00, rd2=8'h00.
- Basic write/read: WE=1, wa=3, wd=8'hA5 on one edge, then WE=0, ra1=3 -> rd1=8'hA5; ra2=2 -> rd2=8'h00.
- Zero register: WE=1, wa=0, wd=8'hFF, edge, ra1=0 -> rd1=8'h00 with ZERO_REG=1. Re-run with ZERO_REG=0 -> rd1=8'hFF.
- Bypass: reg[4]=8'h11. Before the edge drive WE=1, wa=4, wd=8'h3C, ra1=4:
  - BYPASS=1 -> rd1=8'h3C pre-edge.
  - BYPASS=0 -> rd1=8'h11 pre-edge and 8'h3C post-edge.
- Clear priority: reg[1]=8'h22 and reg[6]=8'h77, then clr=1, WE=1, wa=6, wd=8'h99 on one edge -> all registers 8'h00 and rd for address 6 = 8'h00. Pre-edge with ra1=6 -> rd1=8'h77 (no bypass during clr).
- Async reset mid-run: reg[2]=8'h5A, drop reset to 0 between clock edges -> rd1 at ra1=2 reads 8'h00 within the same half-cycle, without a clock edge.
